// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM main controller.
package arm_ctrl_pkg;

  localparam int unsigned NumStates = 10;

  localparam int unsigned IdxFetch    = 0;
  localparam int unsigned IdxDecode   = 1;
  localparam int unsigned IdxMemAdr   = 2;
  localparam int unsigned IdxMemRd    = 3;
  localparam int unsigned IdxMemWb    = 4;
  localparam int unsigned IdxMemWr    = 5;
  localparam int unsigned IdxExecuteR = 6;
  localparam int unsigned IdxExecuteI = 7;
  localparam int unsigned IdxAluWb    = 8;
  localparam int unsigned IdxBranch   = 9;

  typedef enum logic [3:0] {
    StFetch    = 4'(IdxFetch),
    StDecode   = 4'(IdxDecode),
    StMemAdr   = 4'(IdxMemAdr),
    StMemRd    = 4'(IdxMemRd),
    StMemWb    = 4'(IdxMemWb),
    StMemWr    = 4'(IdxMemWr),
    StExecuteR = 4'(IdxExecuteR),
    StExecuteI = 4'(IdxExecuteI),
    StAluWb    = 4'(IdxAluWb),
    StBranch   = 4'(IdxBranch)
  } state_t;

  localparam logic [1:0] AluSrcBRd2  = 2'b00;
  localparam logic [1:0] AluSrcBImm  = 2'b01;
  localparam logic [1:0] AluSrcBFour = 2'b10;

  localparam logic [1:0] ResultAluOut    = 2'b00;
  localparam logic [1:0] ResultData      = 2'b01;
  localparam logic [1:0] ResultAluResult = 2'b10;

  localparam logic [1:0] OpDp  = 2'b00;
  localparam logic [1:0] OpMem = 2'b01;
  localparam logic [1:0] OpBr  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CtrlOff = '0;

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational Moore decode: current state -> datapath controls.
module main_fsm_outdec
  import arm_ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   valid_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = CtrlOff;
    if (valid_i) begin
      case (state_i)
        StFetch: begin
          ctrl_o.alu_src_a  = 1'b1;
          ctrl_o.alu_src_b  = AluSrcBFour;
          ctrl_o.result_src = ResultAluResult;
          ctrl_o.ir_write   = 1'b1;
          ctrl_o.next_pc    = 1'b1;
        end
        StDecode: begin
          ctrl_o.alu_src_a  = 1'b1;
          ctrl_o.alu_src_b  = AluSrcBFour;
          ctrl_o.result_src = ResultAluResult;
        end
        StMemAdr: ctrl_o.alu_src_b = AluSrcBImm;
        StMemRd:  ctrl_o.adr_src = 1'b1;
        StMemWb: begin
          ctrl_o.result_src = ResultData;
          ctrl_o.reg_w      = 1'b1;
        end
        StMemWr: begin
          ctrl_o.adr_src = 1'b1;
          ctrl_o.mem_w   = 1'b1;
        end
        StExecuteR: ctrl_o.alu_op = 1'b1;
        StExecuteI: begin
          ctrl_o.alu_src_b = AluSrcBImm;
          ctrl_o.alu_op    = 1'b1;
        end
        StAluWb: ctrl_o.reg_w = 1'b1;
        StBranch: begin
          ctrl_o.alu_src_b  = AluSrcBImm;
          ctrl_o.result_src = ResultAluResult;
          ctrl_o.branch     = 1'b1;
        end
        default: ctrl_o = CtrlOff;
      endcase
    end
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle ARM main controller FSM (binary or one-hot state register).
// Define ARM_MEMRDY_EN to add MemRdy and stall FETCH/MEMRD/MEMWR on memory wait.
module main_fsm
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned ONEHOT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
`ifdef ARM_MEMRDY_EN
  input  logic       MemRdy,
`endif
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       IllegalOp,
  output logic [3:0] StateDbg
);

  logic   mem_rdy;
  logic   cur_valid;
  logic   [3:0] cur_idx;
  state_t cur_state;
  state_t next_state;
  logic   illegal;
  ctrl_t  ctrl;

`ifdef ARM_MEMRDY_EN
  assign mem_rdy = MemRdy;
`else
  assign mem_rdy = 1'b1;
`endif

  // Only I and S/L bits of Funct steer the sequence.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  if (ONEHOT != 0) begin : g_onehot
    localparam logic [NumStates-1:0] FetchHot = {{(NumStates - 1){1'b0}}, 1'b1};
    logic [NumStates-1:0] state_d, state_q;
    logic [3:0]           hot_cnt, hot_idx;

    always_comb begin
      hot_cnt = '0;
      hot_idx = '0;
      for (int i = 0; i < NumStates; i++) begin
        if (state_q[i]) begin
          hot_cnt = hot_cnt + 4'd1;
          hot_idx = 4'(i);
        end
      end
    end

    assign cur_valid = (hot_cnt == 4'd1);
    assign cur_idx   = cur_valid ? hot_idx : 4'hf;

    always_comb begin
      state_d             = '0;
      state_d[next_state] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FetchHot;
      else       state_q <= state_d;
    end
  end else begin : g_binary
    logic [3:0] state_d, state_q;

    assign cur_valid = (state_q < 4'(NumStates));
    assign cur_idx   = state_q;
    assign state_d   = next_state;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
    end
  end

  assign cur_state = state_t'(cur_idx);

  always_comb begin
    next_state = StFetch;
    illegal    = 1'b0;
    if (cur_valid) begin
      case (cur_state)
        StFetch:  next_state = mem_rdy ? StDecode : StFetch;
        StDecode: begin
          case (Op)
            OpDp:    next_state = Funct[5] ? StExecuteI : StExecuteR;
            OpMem:   next_state = StMemAdr;
            OpBr:    next_state = StBranch;
            default: illegal    = 1'b1;
          endcase
        end
        StMemAdr:   next_state = Funct[0] ? StMemRd : StMemWr;
        StMemRd:    next_state = mem_rdy ? StMemWb : StMemRd;
        StMemWr:    next_state = mem_rdy ? StFetch : StMemWr;
        StExecuteR: next_state = StAluWb;
        StExecuteI: next_state = StAluWb;
        default:    next_state = StFetch;
      endcase
    end
  end

  main_fsm_outdec u_outdec (
    .state_i (cur_state),
    .valid_i (cur_valid),
    .ctrl_o  (ctrl)
  );

  // Enables drop while reset is high; the PC advances only on the fetch that completes.
  always_comb begin
    IRWrite   = ctrl.ir_write & mem_rdy & ~reset;
    NextPC    = ctrl.next_pc & mem_rdy & ~reset;
    RegW      = ctrl.reg_w & ~reset;
    MemW      = ctrl.mem_w & ~reset;
    Branch    = ctrl.branch & ~reset;
    IllegalOp = illegal & ~reset;
    AdrSrc    = ctrl.adr_src;
    ALUSrcA   = ctrl.alu_src_a;
    ALUSrcB   = ctrl.alu_src_b;
    ALUOp     = ctrl.alu_op;
    ResultSrc = ctrl.result_src;
    StateDbg  = cur_idx;
  end

endmodule

// File: tb/tb_main_fsm.sv
// Randomised scoreboard bench for main_fsm; checks binary and one-hot builds side by side.
module tb_main_fsm;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, XR = 6, XI = 7, WB = 8, BR = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemRdy;

  logic       irw_b, adr_b, asa_b, aluop_b, npc_b, regw_b, memw_b, br_b, ill_b;
  logic [1:0] asb_b, rs_b;
  logic [3:0] dbg_b;
  logic       irw_o, adr_o, asa_o, aluop_o, npc_o, regw_o, memw_o, br_o, ill_o;
  logic [1:0] asb_o, rs_o;
  logic [3:0] dbg_o;

  logic [16:0] act_b, act_o, mon_e;
  logic [16:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  main_fsm #(.ONEHOT(0)) dut_bin (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
`ifdef ARM_MEMRDY_EN
    .MemRdy(MemRdy),
`endif
    .IRWrite(irw_b), .AdrSrc(adr_b), .ALUSrcA(asa_b), .ALUSrcB(asb_b), .ALUOp(aluop_b),
    .ResultSrc(rs_b), .NextPC(npc_b), .RegW(regw_b), .MemW(memw_b), .Branch(br_b),
    .IllegalOp(ill_b), .StateDbg(dbg_b)
  );

  main_fsm #(.ONEHOT(1)) dut_oh (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
`ifdef ARM_MEMRDY_EN
    .MemRdy(MemRdy),
`endif
    .IRWrite(irw_o), .AdrSrc(adr_o), .ALUSrcA(asa_o), .ALUSrcB(asb_o), .ALUOp(aluop_o),
    .ResultSrc(rs_o), .NextPC(npc_o), .RegW(regw_o), .MemW(memw_o), .Branch(br_o),
    .IllegalOp(ill_o), .StateDbg(dbg_o)
  );

  assign act_b = {irw_b, adr_b, asa_b, asb_b, aluop_b, rs_b, npc_b, regw_b, memw_b, br_b,
                  ill_b, dbg_b};
  assign act_o = {irw_o, adr_o, asa_o, asb_o, aluop_o, rs_o, npc_o, regw_o, memw_o, br_o,
                  ill_o, dbg_o};

`ifdef ARM_MEMRDY_EN
  localparam bit Stall = 1'b1;
`else
  localparam bit Stall = 1'b0;
`endif

  // Expected output vector for one cycle, straight from the per-state output table.
  function automatic logic [16:0] exp_out(int st, bit rst, bit rdy, bit ill);
    logic irw, adr, asa, aluop, npc, regw, memw, br, il;
    logic [1:0] asb, rs;
    irw = 0; adr = 0; asa = 0; aluop = 0; npc = 0; regw = 0; memw = 0; br = 0; il = 0;
    asb = 2'b00; rs = 2'b00;
    case (st)
      F:   begin asa = 1; asb = 2'b10; rs = 2'b10; irw = rdy; npc = rdy; end
      D:   begin asa = 1; asb = 2'b10; rs = 2'b10; il = ill; end
      MA:  asb = 2'b01;
      MR:  adr = 1;
      MWB: begin rs = 2'b01; regw = 1; end
      MW:  begin adr = 1; memw = 1; end
      XR:  aluop = 1;
      XI:  begin asb = 2'b01; aluop = 1; end
      WB:  regw = 1;
      BR:  begin asb = 2'b01; rs = 2'b10; br = 1; end
      default: ;
    endcase
    if (rst) begin
      irw = 0; npc = 0; regw = 0; memw = 0; br = 0; il = 0;
    end
    return {irw, adr, asa, asb, aluop, rs, npc, regw, memw, br, il, 4'(st)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One abstract state, including any memory wait cycles; Op/Funct are junk outside
  // DECODE and MEMADR since the controller must ignore them there.
  task automatic step(int st, logic [1:0] op, logic [5:0] fn, int fixed_wait);
    int waits;
    bit rdy;
    bit memst;
    memst = (st == F) || (st == MR) || (st == MW);
    waits = 0;
    if (Stall && memst) waits = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
    for (int w = 0; w <= waits; w++) begin
      rdy = (w == waits);
      if (st == D || st == MA) begin
        Op = op;
        Funct = fn;
      end else begin
        Op = 2'($urandom);
        Funct = 6'($urandom);
      end
      MemRdy = memst ? rdy : 1'($urandom);
      exp_q.push_back(exp_out(st, 1'b0, rdy, (st == D) && (op == 2'b11)));
      tick();
    end
  endtask

  task automatic run_instr(logic [1:0] op, logic [5:0] fn, int fetch_wait);
    int path[$];
    path = '{F, D};
    case (op)
      2'b00: begin path.push_back(fn[5] ? XI : XR); path.push_back(WB); end
      2'b01: begin
        path.push_back(MA);
        if (fn[0]) begin path.push_back(MR); path.push_back(MWB); end
        else path.push_back(MW);
      end
      2'b10: path.push_back(BR);
      default: ;
    endcase
    foreach (path[i]) step(path[i], op, fn, (path[i] == F) ? fetch_wait : -1);
  endtask

  task automatic reset_mid_memwr();
    logic [5:0] fn;
    fn = 6'($urandom) & 6'b111110;
    step(F, 2'b01, fn, -1);
    step(D, 2'b01, fn, -1);
    step(MA, 2'b01, fn, -1);
    // Now inside MEMWR: reset must take effect before the sampling edge.
    reset  = 1'b1;
    MemRdy = 1'b1;
    exp_q.push_back(exp_out(F, 1'b1, 1'b1, 1'b0));
    tick();
    exp_q.push_back(exp_out(F, 1'b1, 1'b1, 1'b0));
    tick();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow t=%0t got %h expected nothing queued", $time, act_b);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (act_b !== mon_e) begin
          errors++;
          $display("FAIL outputs_binary t=%0t got %h expected %h", $time, act_b, mon_e);
        end
        checks++;
        if (act_o !== mon_e) begin
          errors++;
          $display("FAIL outputs_onehot t=%0t got %h expected %h", $time, act_o, mon_e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t got still running expected finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] op;
    logic [5:0] fn;
    reset  = 1'b1;
    Op     = 2'b00;
    Funct  = 6'b000000;
    MemRdy = 1'b1;
    tick();
    exp_q.push_back(exp_out(F, 1'b1, 1'b1, 1'b0));
    mon_en = 1'b1;
    tick();
    exp_q.push_back(exp_out(F, 1'b1, 1'b1, 1'b0));
    tick();
    reset = 1'b0;

    run_instr(2'b00, 6'b000000, -1);
    run_instr(2'b01, 6'($urandom) | 6'b000001, -1);
    run_instr(2'b01, 6'($urandom) & 6'b111110, -1);
    run_instr(2'b10, 6'($urandom), -1);
    run_instr(2'b11, 6'($urandom), -1);
    reset_mid_memwr();
`ifdef ARM_MEMRDY_EN
    run_instr(2'b00, 6'b100000, 3);
`endif
    repeat (300) begin
      op = 2'($urandom);
      fn = 6'($urandom);
      run_instr(op, fn, -1);
    end
    mon_en = 1'b0;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
